div_seq_signed: RTL and testbench
=================================

Name: div_seq_signed

Overview:
- Parametrised multi-cycle iterative restoring divider.
- Successor to the unsigned radix-2 divider, adding:
  - a per-operation signed/unsigned mode,
  - a configurable number of quotient bits per cycle,
  - divide-by-zero and signed-overflow flags.
- Fixed latency for every operation.
- Used by the UART auto-baud and timing blocks, and by any datapath needing an occasional divide without a combinational divider.

Parameters:
- W, 32, width of dividend, divisor, quotient and remainder; must be ≥ 4 and even.
- U, 1, quotient bits resolved per OP cycle; legal values are 1, 2 and 4; W must be divisible by U.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only while ready=1.
- sgn  in  1  1 = two's-complement signed divide; 0 = unsigned divide.
- dividend  in  W  numerator; sampled on the accept edge.
- divisor  in  W  denominator; sampled on the accept edge.
- quotient  out  W  result quotient; registered.
- remainder  out  W  result remainder; registered.
- ready  out  1  high in IDLE only.
- done_tick  out  1  one-cycle pulse marking the results valid.
- div_zero  out  1  high when the last operation had divisor == 0; registered.
- overflow  out  1  high when the last operation was signed MIN / -1; registered.

Behaviour:
- Reset (asynchronous): state = IDLE; quotient, remainder, div_zero and overflow = 0; done_tick = 0; ready = 1 once in IDLE.
- States: IDLE → PREP → OP → FIX → DONE → IDLE.
- IDLE:
  - ready = 1.
  - On start=1 at a rising edge: latch dividend, divisor and sgn, then go to PREP.
  - start while not in IDLE is ignored; no queueing.
- PREP (1 cycle):
  - If sgn=1, take the magnitude of each operand and record the quotient sign (XOR of the operand signs) and the remainder sign (the dividend sign).
  - Flag divisor == 0.
  - Flag overflow when sgn=1, dividend = 2^(W-1) and divisor = all-ones.
  - Load the partial remainder with 0; load the iteration counter with W/U.
- OP (W/U cycles):
  - Each cycle performs U chained restoring steps: shift the next dividend MSB into the partial remainder, compare with the divisor, subtract if ≥, and shift the resulting bit into the quotient.
  - Compare and subtract use W+1 bits, so a divisor MSB of 1 and a dividend of 2^(W-1) magnitude are handled.
  - The counter decrements each cycle; go to FIX when it reaches 0.
- FIX (1 cycle): apply the result overrides and sign correction, in this priority:
  1. div_zero: quotient = all-ones; remainder = original dividend (raw bits).
  2. overflow: quotient = 2^(W-1); remainder = 0.
  3. Otherwise, if sgn=1: negate the quotient when the quotient sign is 1; negate the remainder when the dividend sign is 1. The quotient truncates toward zero and the remainder takes the sign of the dividend.
- DONE (1 cycle): done_tick = 1, then go to IDLE.
- Latency:
  - Accept edge = edge 0. done_tick is high in the cycle following edge W/U+2.
  - For W=32: U=1 gives 34 cycles; U=2 gives 18; U=4 gives 10.
  - Latency is fixed; there is no early exit for zero, overflow or small operands.
- Output hold:
  - quotient, remainder, div_zero and overflow update only at the FIX→DONE edge.
  - They hold until the next operation's FIX; they are stable while the next operation runs.
- Back-to-back: start may be asserted in the IDLE cycle immediately after DONE; minimum spacing is W/U+4 cycles.
- Reset mid-operation: abort immediately; all outputs return to their reset values; no done_tick.
- Operand changes after acceptance have no effect.

Test Plan:
- W=32, U=1, unsigned, sgn=0, 100/7 → done_tick exactly 34 cycles after accept; quotient=14, remainder=2, flags 0.
- W=32, U=2, sgn=1:
  - -7/2 (0xFFFFFFF9/0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, latency 18.
  - 7/-2 → quotient=0xFFFFFFFD, remainder=1.
- Unsigned, sgn=0, 0x80000000/0xFFFFFFFF → quotient=0, remainder=0x80000000. Same operands with sgn=1 → quotient=0x80000000, remainder=0, overflow=1.
- 0x00001234/0, both modes → quotient=0xFFFFFFFF, remainder=0x00001234, div_zero=1; the next valid divide clears div_zero.
- Start pulses during OP ignored and operands changed after accept → result matches the original operands; a single done_tick. Back-to-back start in the IDLE cycle right after DONE accepted.
- Assert rst_n=0 at OP cycle 10, then release and run 1000/10 → no done_tick during the aborted operation; outputs are 0 after reset; second result: quotient=100, remainder=0.

Source files
------------

// File: rtl/div_seq_signed.sv
// div_seq_signed: multi-cycle restoring divider with signed/unsigned mode,
// U quotient bits per OP cycle, divide-by-zero and signed-overflow flags.
// Latency is fixed at W/U+2 edges from accept to the results being valid.
module div_seq_signed #(
  parameter int W = 32,
  parameter int U = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         ready,
  output logic         done_tick,
  output logic         div_zero,
  output logic         overflow
);

  localparam int N  = W / U;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_OP   = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         r_state;
  logic           r_sgn;
  logic [W-1:0]   r_dvd;        // raw dividend, kept for the divide-by-zero remainder
  logic [W-1:0]   r_dvs;        // raw divisor at accept, magnitude after PREP
  logic [W-1:0]   r_quo;        // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]   r_rem;        // partial remainder, always < divisor magnitude
  logic [CW-1:0]  r_cnt;
  logic           r_qneg;
  logic           r_rneg;
  logic           r_dz;
  logic           r_ovf;
  logic [W-1:0]   r_quotient;
  logic [W-1:0]   r_remainder;
  logic           r_ready;
  logic           r_done;
  logic           r_div_zero;
  logic           r_overflow;

  logic           w_dvd_neg;
  logic           w_dvs_neg;
  logic [W-1:0]   w_dvd_mag;
  logic [W-1:0]   w_dvs_mag;
  logic           w_dz;
  logic           w_ovf;
  logic [W:0]     w_trial;
  logic [W-1:0]   w_rem_nx;
  logic [W-1:0]   w_quo_nx;
  logic [W-1:0]   w_q_fix;
  logic [W-1:0]   w_r_fix;

  // Operand sign handling and special-case detection, used in PREP.
  assign w_dvd_neg = r_sgn & r_dvd[W-1];
  assign w_dvs_neg = r_sgn & r_dvs[W-1];
  assign w_dvd_mag = w_dvd_neg ? (-r_dvd) : r_dvd;
  assign w_dvs_mag = w_dvs_neg ? (-r_dvs) : r_dvs;
  assign w_dz      = (r_dvs == {W{1'b0}});
  assign w_ovf     = r_sgn && (r_dvd == {1'b1, {(W-1){1'b0}}}) && (&r_dvs);

  // U chained restoring steps; the trial value is W+1 bits so a full-range divisor compares correctly.
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    w_trial  = {(W+1){1'b0}};
    for (int k = 0; k < U; k++) begin
      w_trial = {w_rem_nx, w_quo_nx[W-1]};
      if (w_trial >= {1'b0, r_dvs}) begin
        w_rem_nx = w_trial[W-1:0] - r_dvs;
        w_quo_nx = {w_quo_nx[W-2:0], 1'b1};
      end else begin
        w_rem_nx = w_trial[W-1:0];
        w_quo_nx = {w_quo_nx[W-2:0], 1'b0};
      end
    end
  end

  // Result overrides in priority order, then sign correction of the magnitudes.
  always_comb begin
    w_q_fix = r_quo;
    w_r_fix = r_rem;
    if (r_dz) begin
      w_q_fix = {W{1'b1}};
      w_r_fix = r_dvd;
    end else if (r_ovf) begin
      w_q_fix = {1'b1, {(W-1){1'b0}}};
      w_r_fix = {W{1'b0}};
    end else begin
      w_q_fix = r_qneg ? (-r_quo) : r_quo;
      w_r_fix = r_rneg ? (-r_rem) : r_rem;
    end
  end

  // Control FSM and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sgn       <= 1'b0;
      r_dvd       <= {W{1'b0}};
      r_dvs       <= {W{1'b0}};
      r_quo       <= {W{1'b0}};
      r_rem       <= {W{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_quotient  <= {W{1'b0}};
      r_remainder <= {W{1'b0}};
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_sgn   <= sgn;
            r_ready <= 1'b0;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_quo   <= w_dvd_mag;
          r_dvs   <= w_dvs_mag;
          r_rem   <= {W{1'b0}};
          r_cnt   <= CW'(N);
          r_qneg  <= w_dvd_neg ^ w_dvs_neg;
          r_rneg  <= w_dvd_neg;
          r_dz    <= w_dz;
          r_ovf   <= w_ovf;
          r_state <= S_OP;
        end
        S_OP: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
          r_div_zero  <= r_dz;
          r_overflow  <= r_ovf;
          r_done      <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign ready     = r_ready;
  assign done_tick = r_done;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_div_seq_signed.sv
// Bench for div_seq_signed: three instances (U=1,2,4, W=32) share stimulus;
// an arithmetic reference model predicts acceptance, latency and results.
module tb_div_seq_signed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [31:0] divisor;

  logic [31:0] q_o [3];
  logic [31:0] r_o [3];
  logic        rdy_o [3];
  logic        dn_o [3];
  logic        dz_o [3];
  logic        ov_o [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model state per instance
  bit          busy [3];
  int          acc [3];
  logic [31:0] pq [3], pr [3], hq [3], hr [3];
  logic        pdz [3], pov [3], hdz [3], hov [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    div_seq_signed #(.W(32), .U(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
      .dividend(dividend), .divisor(divisor),
      .quotient(q_o[g]), .remainder(r_o[g]), .ready(rdy_o[g]),
      .done_tick(dn_o[g]), .div_zero(dz_o[g]), .overflow(ov_o[g]));
  end

  function automatic int lat_of(input int i);
    return (32 >> i) + 2;
  endfunction

  // Reference divide from the arithmetic rules (C-style signed truncation).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic ov);
    logic signed [31:0] sa, sb;
    sa = a; sb = b; dz = 1'b0; ov = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got %h expected %h (cycle %0d)", nm, 1 << i, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: accept when idle, results appear lat edges later, idle one edge after that.
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] mq, mr;
    logic mdz, mov;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        busy[i] <= 1'b0; acc[i] <= 0;
        hq[i] <= 32'd0; hr[i] <= 32'd0; hdz[i] <= 1'b0; hov[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (busy[i]) begin
          if (cyc == acc[i] + lat_of(i)) begin
            hq[i] <= pq[i]; hr[i] <= pr[i]; hdz[i] <= pdz[i]; hov[i] <= pov[i];
          end
          if (cyc == acc[i] + lat_of(i) + 1) busy[i] <= 1'b0;
        end else if (start) begin
          model(dividend, divisor, sgn, mq, mr, mdz, mov);
          busy[i] <= 1'b1; acc[i] <= cyc;
          pq[i] <= mq; pr[i] <= mr; pdz[i] <= mdz; pov[i] <= mov;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("ready", i, {31'd0, rdy_o[i]}, {31'd0, !busy[i]});
        chk("done_tick", i, {31'd0, dn_o[i]},
            {31'd0, (busy[i] && (cyc == acc[i] + lat_of(i) + 1))});
        chk("quotient", i, q_o[i], hq[i]);
        chk("remainder", i, r_o[i], hr[i]);
        chk("div_zero", i, {31'd0, dz_o[i]}, {31'd0, hdz[i]});
        chk("overflow", i, {31'd0, ov_o[i]}, {31'd0, hov[i]});
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = !busy[0] && !busy[1] && !busy[2];
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: got busy expected idle within 300 cycles");
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; sgn = s;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; sgn = ~s;
    wait_idle();
  endtask

  task automatic lit(input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
    for (int i = 0; i < 3; i++) begin
      chk("lit_quotient", i, q_o[i], q);
      chk("lit_remainder", i, r_o[i], r);
      chk("lit_div_zero", i, {31'd0, dz_o[i]}, {31'd0, dz});
      chk("lit_overflow", i, {31'd0, ov_o[i]}, {31'd0, ov});
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(1, 20);
      6: return 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] mq, mr;
    logic mdz, mov;
    bit seen;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dividend = 32'd0; divisor = 32'd0;

    // Pin the reference model with hand-computed values.
    model(32'd100, 32'd7, 1'b0, mq, mr, mdz, mov);
    chk("pin_q_100_7", 0, mq, 32'd14);
    chk("pin_r_100_7", 0, mr, 32'd2);
    model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, mdz, mov);
    chk("pin_q_m7_2", 0, mq, 32'hFFFF_FFFD);
    chk("pin_r_m7_2", 0, mr, 32'hFFFF_FFFF);
    model(32'd7, 32'hFFFF_FFFE, 1'b1, mq, mr, mdz, mov);
    chk("pin_q_7_m2", 0, mq, 32'hFFFF_FFFD);
    chk("pin_r_7_m2", 0, mr, 32'd1);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mdz, mov);
    chk("pin_ovf", 0, {31'd0, mov}, 32'd1);

    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases
    do_op(32'd100, 32'd7, 1'b0);                     lit(32'd14, 32'd2, 1'b0, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);               lit(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1);               lit(32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);       lit(32'd0, 32'h8000_0000, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);       lit(32'h8000_0000, 32'd0, 1'b0, 1'b1);
    do_op(32'h0000_1234, 32'd0, 1'b0);               lit(32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
    do_op(32'h0000_1234, 32'd0, 1'b1);               lit(32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
    do_op(32'd1000, 32'd10, 1'b1);                   lit(32'd100, 32'd0, 1'b0, 1'b0);

    // Start pulses while busy are ignored; operands changed after accept
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000000; divisor = 32'd3; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0; dividend = 32'd5; divisor = 32'd5;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9); sgn = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    lit(32'd333333, 32'd1, 1'b0, 1'b0);

    // Back-to-back: start in the IDLE cycle right after the U=1 DONE cycle
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd7; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = dn_o[0];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_done: got no done_tick expected one within 60 cycles");
    end
    @(negedge clk);
    start = 1'b1; dividend = 32'd81; divisor = 32'd9; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    lit(32'd9, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; dividend = 32'd12345; divisor = 32'd67; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    lit(32'd0, 32'd0, 1'b0, 1'b0);
    do_op(32'd1000, 32'd10, 1'b0);
    lit(32'd100, 32'd0, 1'b0, 1'b0);

    // Randomized traffic, including starts while busy
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      dividend = pick(); divisor = pick(); sgn = $urandom_range(0, 1);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
